// File: rtl/pcileech_rst_seq_led.sv
// Reset sequencer with PERST# glitch filter, staged reset release, link-up watchdog
// and active-low LED driver with off/on/slow/fast blink modes.
module pcileech_rst_seq_led #(
    parameter int unsigned NUM_RST       = 3,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned STAGE_GAP     = 8,
    parameter int unsigned LINK_TIMEOUT  = 0,
    parameter int unsigned NUM_LED       = 2,
    parameter int unsigned BLINK_LOG2    = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcie_perst_n,
    input  logic                   pcie_lnk_up,
    input  logic [2*NUM_LED-1:0]   led_mode,
    output logic [NUM_RST-1:0]     rst_out,
    output logic                   seq_done,
    output logic [3:0]             retry_cnt,
    output logic [1:0]             seq_state,
    output logic [NUM_LED-1:0]     led_n
);

    localparam int unsigned FLT_W   = $clog2(FILTER_CYCLES) + 1;
    localparam int unsigned SEQ_MAX = HOLD_CYCLES + (NUM_RST - 1) * STAGE_GAP;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX) + 1;
    localparam int unsigned WD_W    = $clog2(LINK_TIMEOUT + 1) + 1;
    localparam int unsigned BLK_W   = BLINK_LOG2 + 1;

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_HOLD  = 2'b01,
        S_STAGE = 2'b10,
        S_RUN   = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 filt_q, filt_d;
    logic [FLT_W-1:0]     run_q, run_d;
    logic [SEQ_W-1:0]     seq_cnt_q, seq_cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [NUM_RST-1:0]   rst_out_q, rst_out_d;
    logic                 seq_done_q, seq_done_d;
    logic [3:0]           retry_q, retry_d;
    logic [BLK_W-1:0]     blink_q;
    logic [NUM_LED-1:0]   led_n_q, led_n_d;
    logic                 wd_expired_c;

    // PERST# filter: toggle after FILTER_CYCLES consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (pcie_perst_n != filt_q) begin
            if (run_q == FLT_W'(FILTER_CYCLES - 1)) begin
                filt_d = ~filt_q;
            end else begin
                run_d = run_q + FLT_W'(1);
            end
        end
    end

    assign wd_expired_c = (LINK_TIMEOUT != 0) && (wd_q == WD_W'(LINK_TIMEOUT));

    // Sequencer next state; a low filtered PERST# always wins over the watchdog
    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = seq_cnt_q;
        rst_out_d  = rst_out_q;
        seq_done_d = seq_done_q;
        retry_d    = retry_q;
        wd_d       = '0;
        case (state_q)
            S_RESET: begin
                rst_out_d  = '1;
                seq_done_d = 1'b0;
                seq_cnt_d  = '0;
                if (filt_d && !filt_q) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD, S_STAGE: begin
                if (!filt_q) begin
                    state_d    = S_RESET;
                    rst_out_d  = '1;
                    seq_done_d = 1'b0;
                    seq_cnt_d  = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                    for (int unsigned k = 0; k < NUM_RST; k++) begin
                        rst_out_d[k] = seq_cnt_d < SEQ_W'(HOLD_CYCLES + k * STAGE_GAP);
                    end
                    if (seq_cnt_d >= SEQ_W'(SEQ_MAX)) begin
                        state_d    = S_RUN;
                        seq_done_d = 1'b1;
                    end else if (seq_cnt_d >= SEQ_W'(HOLD_CYCLES)) begin
                        state_d = S_STAGE;
                    end
                end
            end
            S_RUN: begin
                if (!filt_q) begin
                    state_d    = S_RESET;
                    rst_out_d  = '1;
                    seq_done_d = 1'b0;
                    seq_cnt_d  = '0;
                end else if (wd_expired_c) begin
                    state_d    = S_HOLD;
                    rst_out_d  = '1;
                    seq_done_d = 1'b0;
                    seq_cnt_d  = '0;
                    retry_d    = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
                end else if (LINK_TIMEOUT != 0 && !pcie_lnk_up) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    // LED decode from the current blink counter
    always_comb begin
        led_n_d = '1;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            case (led_mode[2*i +: 2])
                2'b00:   led_n_d[i] = 1'b1;
                2'b01:   led_n_d[i] = 1'b0;
                2'b10:   led_n_d[i] = ~blink_q[BLINK_LOG2];
                default: led_n_d[i] = ~blink_q[BLINK_LOG2-2];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            filt_q     <= 1'b0;
            run_q      <= '0;
            seq_cnt_q  <= '0;
            wd_q       <= '0;
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
            retry_q    <= '0;
            blink_q    <= '0;
            led_n_q    <= '1;
        end else begin
            state_q    <= state_d;
            filt_q     <= filt_d;
            run_q      <= run_d;
            seq_cnt_q  <= seq_cnt_d;
            wd_q       <= wd_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
            retry_q    <= retry_d;
            blink_q    <= blink_q + BLK_W'(1);
            led_n_q    <= led_n_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign seq_done  = seq_done_q;
    assign retry_cnt = retry_q;
    assign seq_state = state_q;
    assign led_n     = led_n_q;

endmodule
